// File: rtl/nano_pkg.sv
// Shared widths, entry type and register-mask helper for the nano processor
// register write path.
package nano_pkg;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // R0 never reports as busy, so its bit is always cleared.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return (NUM_REGS'(1) << a) & ~NUM_REGS'(1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending register writes; exposes per-entry valid/address
// so the owner can build a register busy mask.
module wb_fifo
  import nano_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  wb_entry_t                    entry_i,
  output wb_entry_t                    head_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [DEPTH-1:0]             ent_vld_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i & (cnt_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i  & ~flush_i & (cnt_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  function automatic logic slot_valid(input int idx, input logic [PTR_W-1:0] rd,
                                      input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = PTR_W'(idx) - rd;
    return CNT_W'(off) < cnt;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld_o[i]  = slot_valid(i, rd_ptr_q, cnt_q);
      ent_addr_o[i] = mem_q[i].addr;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side driver for the 8 x 4-bit register bank: handshake, R0 filter,
// in-order buffering, registered bank outputs and read-after-write busy mask.
module reg_writeback_unit
  import nano_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Wr_Valid,
  output logic                Wr_Ready,
  input  logic [ADDR_W-1:0]   Wr_Addr,
  input  logic [DATA_W-1:0]   Wr_Data,
  input  logic                Flush,
  output logic [ADDR_W-1:0]   Reg_En,
  output logic [DATA_W-1:0]   ValStore,
  output logic [NUM_REGS-1:0] Busy_Mask,
  output logic [CNT_W-1:0]    Pending_Cnt
);

  wb_entry_t                    req, head;
  logic [CNT_W-1:0]             cnt;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic                         accept, push, pop;
  logic [ADDR_W-1:0]            reg_en_q, reg_en_d;
  logic [DATA_W-1:0]            val_q, val_d;
  logic [NUM_REGS-1:0]          busy;

  // Ready depends only on state and Flush, never on Wr_Valid.
  assign Wr_Ready = (cnt < CNT_W'(DEPTH)) & ~Flush;
  assign accept   = Wr_Valid & Wr_Ready;
  assign push     = accept & (Wr_Addr != REG_ZERO);
  assign pop      = (cnt != '0) & ~Flush;

  assign req.addr = Wr_Addr;
  assign req.data = Wr_Data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (Flush),
    .entry_i    (req),
    .head_o     (head),
    .count_o    (cnt),
    .ent_vld_o  (ent_vld),
    .ent_addr_o (ent_addr)
  );

  always_comb begin
    reg_en_d = '0;
    val_d    = '0;
    if (pop) begin
      reg_en_d = head.addr;
      val_d    = head.data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      reg_en_q <= '0;
      val_q    <= '0;
    end else begin
      reg_en_q <= reg_en_d;
      val_q    <= val_d;
    end
  end

  // Reg_En = 0 maps to no bit because reg_onehot clears the R0 position.
  always_comb begin
    busy = reg_onehot(reg_en_q);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) busy = busy | reg_onehot(ent_addr[i]);
    end
  end

  assign Reg_En      = reg_en_q;
  assign ValStore    = val_q;
  assign Busy_Mask   = busy;
  assign Pending_Cnt = cnt;

endmodule
